// File: rtl/serial_comp_pkg.sv
// Shared types and constants for the serial comparator controller.
// State encoding, default operand width and index-width helper.
package serial_comp_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int idx_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_comp_ctrl_comparator_1bit.sv
// Single-bit magnitude comparator used by the serial compare loop.
// o1: A>B, o2: A==B, o3: A<B.
module comparator_1bit (
  input  logic A,
  input  logic B,
  output logic o1,
  output logic o2,
  output logic o3
);

  assign o1 = A & ~B;
  assign o2 = ~(A ^ B);
  assign o3 = ~A & B;

endmodule

// File: rtl/serial_comp_ctrl.sv
// Bit-serial MSB-first unsigned comparator with IDLE/SHIFT/DONE control.
// Define SERIAL_COMP_EARLY_EXIT_EN to finish on the first differing bit.
module serial_comp_ctrl #(
  parameter int WIDTH = serial_comp_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  import serial_comp_pkg::*;

  localparam int IW = idx_w(WIDTH);
  localparam logic [IW-1:0] LP_TOP = IW'(WIDTH - 1);
  localparam logic [IW-1:0] LP_ONE = IW'(1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_found;
  logic             r_fgt;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic w_bgt;
  logic w_beq;
  logic w_blt;
  logic w_last;
  logic w_diff_new;
  logic w_fnd;
  logic w_fgt;
  logic w_to_done;

  comparator_1bit u_cmp (
    .A  (r_a[WIDTH-1]),
    .B  (r_b[WIDTH-1]),
    .o1 (w_bgt),
    .o2 (w_beq),
    .o3 (w_blt)
  );

  assign w_last     = (r_idx == '0);
  assign w_diff_new = ~r_found & ~w_beq;
  assign w_fnd      = r_found | ~w_beq;
  assign w_fgt      = r_found ? r_fgt : (w_bgt & ~w_blt);
  assign w_to_done  = (r_state == S_SHIFT) && (w_next == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; start is only honoured in IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        if (w_last || w_diff_new) w_next = S_DONE;
`else
        if (w_last) w_next = S_DONE;
`endif
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand shifting, bit index and first-difference record
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_found <= 1'b0;
      r_fgt   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= LP_TOP;
            r_found <= 1'b0;
            r_fgt   <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_a <= {r_a[WIDTH-2:0], 1'b0};
          r_b <= {r_b[WIDTH-2:0], 1'b0};
          if (!w_last) r_idx <= r_idx - LP_ONE;
          if (w_diff_new) begin
            r_found <= 1'b1;
            r_fgt   <= w_bgt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result flags load on entry to DONE and hold until the next result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gt <= 1'b0;
      r_eq <= 1'b0;
      r_lt <= 1'b0;
    end else if (w_to_done) begin
      r_gt <= w_fnd & w_fgt;
      r_eq <= ~w_fnd;
      r_lt <= w_fnd & ~w_fgt;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Self-checking bench for serial_comp_ctrl (WIDTH=8).
// Cycle model is a countdown of the expected latency per accepted run.
module tb_serial_comp_ctrl;

  localparam int W = 8;

`ifdef SERIAL_COMP_EARLY_EXIT_EN
  localparam int L80  = 2;
  localparam int L01  = 8;
  localparam int LMSB = 2;
  localparam int L10  = 4;
`else
  localparam int L80  = 9;
  localparam int L01  = 9;
  localparam int LMSB = 9;
  localparam int L10  = 9;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         gt;
  logic         eq;
  logic         lt;

  int n_checks = 0;
  int n_fail = 0;

  int         m_cnt = 0;
  logic [2:0] m_flags = 3'b000;
  logic [2:0] m_pend = 3'b000;

  always #5 clk = ~clk;

  serial_comp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic int lat_of(input logic [W-1:0] x,
                                input logic [W-1:0] y);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = W - 1; i >= 0; i--)
      if (d[i]) return (W - i) + 1;
`endif
    return W + 1;
  endfunction

  function automatic logic [2:0] res_of(input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    return 3'b010;
  endfunction

  // Model advances on each edge, then outputs are compared 1 time unit later
  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_cnt   = 0;
      m_flags = 3'b000;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt  = lat_of(a, b);
        m_pend = res_of(a, b);
      end
    end else begin
      m_cnt = m_cnt - 1;
    end
    if (m_cnt == 1) m_flags = m_pend;
    #1;
    chk("busy", 32'(busy), 32'(m_cnt > 0));
    chk("done", 32'(done), 32'(m_cnt == 1));
    chk("flags", 32'({gt, eq, lt}), 32'(m_flags));
  end

  task automatic run_dir(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2:0] ef, input int el,
                         input string nm);
    int n;
    bit got;
    n = 0;
    got = 0;
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
      end
      if (done) got = 1;
    end
    chk({nm, "_lat"}, 32'(n), 32'(el));
    chk({nm, "_res"}, 32'({gt, eq, lt}), 32'(ef));
  endtask

  initial begin
    int n;
    int m;
    int seen;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_flags", 32'({gt, eq, lt}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_dir(8'hA5, 8'hA5, 3'b010, 9, "a5_eq");
    run_dir(8'h80, 8'h7F, 3'b100, L80, "msb_gt");
    run_dir(8'h01, 8'h02, 3'b001, L01, "bit1_lt");
    run_dir(8'h0F, 8'hF0, 3'b001, LMSB, "b2b_lt");
    run_dir(8'hF0, 8'h0F, 3'b100, LMSB, "b2b_gt");

    // start held high; operands change right after acceptance
    @(negedge clk);
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        a = 8'h30;
        b = 8'h30;
      end
      if (done) break;
    end
    chk("held1_lat", 32'(n), 32'(L10));
    chk("held1_res", 32'({gt, eq, lt}), 32'(3'b001));
    m = 0;
    while (m < 40) begin
      @(negedge clk);
      m++;
      if (done) break;
    end
    chk("held_gap", 32'(m), 32'(10));
    chk("held2_res", 32'({gt, eq, lt}), 32'(3'b010));
    start = 1'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of a run
    a = 8'h3C;
    b = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_flags", 32'({gt, eq, lt}), 32'(0));
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_nodone", 32'(seen), 32'(0));
    run_dir(8'hFF, 8'h00, 3'b100, LMSB, "post_rst_gt");

    // randomized traffic, including starts while busy and rare resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (8'd1 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      rst_n = ($urandom_range(0, 79) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_comp_ctrl.md
SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin a comparison; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, operand A; captured on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH, operand B; captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 The block SHALL have ports gt, eq and lt, output, 1 each, flagging A>B, A==B and A<B (unsigned), one-hot once any result exists.

Function
REQ-010 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-011 The block SHALL, in IDLE with start=1, capture a and b into shift registers, set bit index to WIDTH-1, clear the first-difference record and go to SHIFT.
REQ-012 The block SHALL compare exactly one bit pair per SHIFT cycle, MSB first, using one 1-bit comparator instance.
REQ-013 The block SHALL record as the result the first bit position where A and B differ: A bit 1 gives gt, B bit 1 gives lt.
REQ-014 The block SHALL ignore every later difference once a difference has been recorded.
REQ-015 The block SHALL go to DONE after processing bit index 0, with no difference found meaning eq.
REQ-016 The block SHALL, in DONE, assert done for exactly one cycle, update gt/eq/lt in the same cycle and return to IDLE on the next edge.
REQ-017 The block SHALL hold gt/eq/lt stable from the done pulse until the next done pulse.
REQ-018 The block SHALL ignore start while busy=1, including in DONE; a new start is accepted no sooner than the cycle after DONE.
REQ-019 The block SHALL NOT be affected by changes on a and b after capture.
REQ-020 The block SHALL, with no early exit, assert done at edge WIDTH+1 after the accepting edge.

Reset
REQ-021 The block SHALL, on rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, gt=0, eq=0, lt=0, shift registers and index cleared.
REQ-022 The block SHALL, on reset during SHIFT or DONE, abort the operation and produce no done pulse; the first start after reset is accepted normally.
REQ-023 The block SHALL give rst_n priority over start in the same cycle.

Configuration
REQ-024 Macro SERIAL_COMP_EARLY_EXIT_EN SHALL control early exit.
REQ-025 With SERIAL_COMP_EARLY_EXIT_EN defined, the block SHALL go from SHIFT to DONE on the edge that detects the first difference; latency is k+1 edges for a first difference at the k-th compared bit (k=1 for MSB).
REQ-026 Without SERIAL_COMP_EARLY_EXIT_EN, the block SHALL always take WIDTH SHIFT cycles (constant latency WIDTH+1) with identical result values.

Structure
REQ-027 The state encoding (IDLE/SHIFT/DONE) and the default WIDTH constant SHALL reside in the shared package serial_comp_pkg.
REQ-028 The bit comparison SHALL be made by the existing sub-module comparator_1bit (ports A, B, o1=A>B, o2=A==B, o3=A<B), instantiated once; no other sub-modules.

Verification (WIDTH=8)
REQ-029 a=0xA5, b=0xA5, one-cycle start -> done at edge 9, eq=1, gt=lt=0, busy high for edges 1..9.
REQ-030 a=0x80, b=0x7F -> gt=1; done at edge 2 with SERIAL_COMP_EARLY_EXIT_EN, edge 9 without.
REQ-031 a=0x01, b=0x02 -> lt=1 (difference at bit 1), done at edge 8 with early exit, edge 9 without.
REQ-032 start held high continuously with a=0x10, b=0x20 then a=0x30, b=0x30 applied after acceptance -> only the first operands compared (lt=1); the second run starts the cycle after DONE; starts pulsed during busy produce no extra done.
REQ-033 rst_n=0 for one cycle at edge 4 of a run -> no done pulse, all outputs 0; a following start with a=0xFF, b=0x00 -> gt=1.
REQ-034 Back-to-back runs 0x0F vs 0xF0, then 0xF0 vs 0x0F -> lt then gt; flags hold between done pulses and stay one-hot.
